// File: rtl/kat_adc_pkg.sv
// Shared definitions for the KATADC 3-wire config link, imported by both the
// controller and the responder sides.
package kat_adc_pkg;

    localparam logic [11:0] KATADC_HDR = 12'h001;
    localparam int FRAME_BITS = 32;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } adc3w_state_t;

endpackage

// File: rtl/kat_sync_edge.sv
// N-stage synchronizer for an asynchronous input, with single-cycle rise/fall
// pulses derived from the synchronized value against a one-flop history.
module kat_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~hist_q;
    assign fall = ~dout & hist_q;

endmodule

// File: rtl/kat_adc3wire_responder.sv
// ADC-side responder for the KATADC 3-wire link: shifts in 32-bit write frames,
// validates them and updates a flop-based 16 x 16-bit register file.
module kat_adc3wire_responder
    import kat_adc_pkg::*;
#(
    parameter logic [11:0]       HEADER      = KATADC_HDR,
    parameter int                NREGS       = 16,
    parameter logic [DATA_W-1:0] DEFAULT_VAL = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst_n,
    input  logic              adc3wire_clk,
    input  logic              adc3wire_data,
    input  logic              adc3wire_strobe,
    input  logic              adc_reset,
    output logic              reg_wr_valid,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_err,
    output logic              hdr_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic sdata_s, sdata_rise, sdata_fall;
    logic strb_s, strb_rise, strb_fall;

    kat_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk   (OPB_Clk),
        .rst_n (OPB_Rst_n),
        .din   (adc3wire_clk),
        .dout  (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    kat_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
        .clk   (OPB_Clk),
        .rst_n (OPB_Rst_n),
        .din   (adc3wire_data),
        .dout  (sdata_s),
        .rise  (sdata_rise),
        .fall  (sdata_fall)
    );

    // Strobe idles high, so its synchronizer resets high to avoid a false edge.
    kat_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_strb (
        .clk   (OPB_Clk),
        .rst_n (OPB_Rst_n),
        .din   (adc3wire_strobe),
        .dout  (strb_s),
        .rise  (strb_rise),
        .fall  (strb_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, sclk_fall, sdata_rise, sdata_fall, strb_s};

    adc3w_state_t          state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_ok, ferr, herr;
    logic [ADDR_W-1:0]     frm_addr;
    logic [DATA_W-1:0]     frm_data;
    logic [11:0]           frm_hdr;

    assign frm_hdr  = shift_q[FRAME_BITS-1 -: 12];
    assign frm_addr = shift_q[DATA_W +: ADDR_W];
    assign frm_data = shift_q[DATA_W-1:0];

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wr_ok   = 1'b0;
        ferr    = 1'b0;
        herr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (strb_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // A strobe release closes the frame even if a clock edge
                // arrives in the same cycle; that last bit is not counted.
                if (strb_rise) begin
                    state_d = CHECK;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], sdata_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (cnt_q != CNT_FRAME) begin
                    ferr = 1'b1;
                end else if (frm_hdr != HEADER) begin
                    herr = 1'b1;
                end else begin
                    wr_ok = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            frame_err    <= 1'b0;
            hdr_err      <= 1'b0;
        end else begin
            reg_wr_valid <= wr_ok;
            frame_err    <= ferr;
            hdr_err      <= herr;
            if (wr_ok) begin
                reg_wr_addr <= frm_addr;
                reg_wr_data <= frm_data;
            end
        end
    end

    assign busy = (state_q == SHIFT);

    logic [DATA_W-1:0] regs_q [NREGS];

    // adc_reset takes priority over a write landing in the same cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= DEFAULT_VAL;
            end
        end else if (adc_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= DEFAULT_VAL;
            end
        end else if (wr_ok) begin
            regs_q[frm_addr] <= frm_data;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= regs_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_kat_adc3wire_responder.sv
// Bench for kat_adc3wire_responder: directed link scenarios plus randomized
// frames checked against a register-file/event model.
module tb_kat_adc3wire_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        sdata = 1'b0;
    logic        strobe = 1'b1;
    logic        adc_reset = 1'b0;
    logic [3:0]  rd_addr = 4'h0;
    logic        reg_wr_valid, frame_err, hdr_err, busy;
    logic [3:0]  reg_wr_addr;
    logic [15:0] reg_wr_data, rd_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int n_valid = 0, n_ferr = 0, n_herr = 0;
    logic [19:0] wr_q[$];
    logic [15:0] model [16];

    kat_adc3wire_responder dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .adc3wire_clk    (sclk),
        .adc3wire_data   (sdata),
        .adc3wire_strobe (strobe),
        .adc_reset       (adc_reset),
        .reg_wr_valid    (reg_wr_valid),
        .reg_wr_addr     (reg_wr_addr),
        .reg_wr_data     (reg_wr_data),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .frame_err       (frame_err),
        .hdr_err         (hdr_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (reg_wr_valid === 1'b1) begin
            n_valid++;
            wr_q.push_back({reg_wr_addr, reg_wr_data});
        end
        if (frame_err === 1'b1) n_ferr++;
        if (hdr_err === 1'b1) n_herr++;
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mkframe(input logic [11:0] h, input logic [3:0] a,
                                            input logic [15:0] d);
        return {h, a, d};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    task automatic serial_bit(input logic b);
        @(negedge clk);
        sclk = 1'b0;
        sdata = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        strobe = 1'b1;
    endtask

    task automatic shift_frame(input logic [63:0] bits, input int n);
        frame_start();
        for (int i = n - 1; i >= 0; i--) serial_bit(bits[i]);
        frame_end();
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1;
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        clear_model();
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({reg_wr_valid, frame_err, hdr_err, busy} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", {reg_wr_valid, frame_err, hdr_err, busy});
        end else pass_cnt++;
        chk_cnt++;
        if ({reg_wr_addr, reg_wr_data, rd_data} !== 36'h0) begin
            $display("FAIL reset_data: got %h want 0", {reg_wr_addr, reg_wr_data, rd_data});
        end else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d);
            chk_cnt++;
            if (d !== model[i]) $display("FAIL reset_reg%0d: got %h want %h", i, d, model[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_beef();
        int lat, v0;
        logic [15:0] d;
        v0 = n_valid;
        shift_frame({32'h0, mkframe(12'h001, 4'h3, 16'hBEEF)}, 32);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (reg_wr_valid || frame_err || hdr_err) begin
                lat = k;
                break;
            end
        end
        chk_cnt++;
        if (lat !== 4) $display("FAIL beef_latency: got %0d want 4", lat);
        else pass_cnt++;
        repeat (6) @(negedge clk);
        model[3] = 16'hBEEF;
        chk_cnt++;
        if (n_valid !== v0 + 1) $display("FAIL beef_count: got %0d want %0d", n_valid, v0 + 1);
        else pass_cnt++;
        chk_cnt++;
        if ({reg_wr_addr, reg_wr_data} !== 20'h3BEEF) begin
            $display("FAIL beef_hold: got %h want 3BEEF", {reg_wr_addr, reg_wr_data});
        end else pass_cnt++;
        rd(4'h3, d);
        chk_cnt++;
        if (d !== 16'hBEEF) $display("FAIL beef_read: got %h want BEEF", d);
        else pass_cnt++;
    endtask

    task automatic test_hdr_err();
        int v0, h0, f0;
        logic [15:0] d;
        v0 = n_valid; h0 = n_herr; f0 = n_ferr;
        shift_frame({32'h0, mkframe(12'h002, 4'h5, 16'h1234)}, 32);
        repeat (8) @(negedge clk);
        chk_cnt++;
        if (n_herr !== h0 + 1 || n_valid !== v0 || n_ferr !== f0) begin
            $display("FAIL hdr_err_pulses: got h%0d v%0d f%0d want h%0d v%0d f%0d",
                     n_herr, n_valid, n_ferr, h0 + 1, v0, f0);
        end else pass_cnt++;
        rd(4'h5, d);
        chk_cnt++;
        if (d !== model[5]) $display("FAIL hdr_err_reg5: got %h want %h", d, model[5]);
        else pass_cnt++;
    endtask

    task automatic test_frame_len();
        int v0, f0, lens[2];
        logic [15:0] d;
        lens[0] = 31; lens[1] = 34;
        for (int t = 0; t < 2; t++) begin
            v0 = n_valid; f0 = n_ferr;
            shift_frame({32'h0, mkframe(12'h001, 4'h3, 16'h7777)} << (lens[t] - 32 + 1), lens[t]);
            repeat (8) @(negedge clk);
            chk_cnt++;
            if (n_ferr !== f0 + 1 || n_valid !== v0) begin
                $display("FAIL frame_len%0d: got f%0d v%0d want f%0d v%0d",
                         lens[t], n_ferr, n_valid, f0 + 1, v0);
            end else pass_cnt++;
        end
        rd(4'h3, d);
        chk_cnt++;
        if (d !== model[3]) $display("FAIL frame_len_reg3: got %h want %h", d, model[3]);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int v0, f0;
        logic [31:0] w;
        w = mkframe(12'h001, 4'hA, 16'h1357);
        v0 = n_valid; f0 = n_ferr;
        frame_start();
        for (int i = 31; i >= 1; i--) serial_bit(w[i]);
        @(negedge clk);
        sclk = 1'b0;
        sdata = w[0];
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        strobe = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (n_ferr !== f0 + 1 || n_valid !== v0) begin
            $display("FAIL simul_edge: got f%0d v%0d want f%0d v%0d", n_ferr, n_valid, f0 + 1, v0);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [15:0] d;
        v0 = n_valid;
        shift_frame({32'h0, mkframe(12'h001, 4'h0, 16'h0001)}, 32);
        repeat (2) @(negedge clk);
        shift_frame({32'h0, mkframe(12'h001, 4'hF, 16'hFFFF)}, 32);
        repeat (8) @(negedge clk);
        model[0] = 16'h0001;
        model[15] = 16'hFFFF;
        chk_cnt++;
        if (n_valid !== v0 + 2) $display("FAIL b2b_count: got %0d want %0d", n_valid, v0 + 2);
        else pass_cnt++;
        chk_cnt++;
        if (wr_q.size() < 2 || wr_q[wr_q.size() - 2] !== 20'h00001 || wr_q[wr_q.size() - 1] !== 20'hFFFFF) begin
            $display("FAIL b2b_order: got %h,%h want 00001,FFFFF",
                     wr_q[wr_q.size() - 2], wr_q[wr_q.size() - 1]);
        end else pass_cnt++;
        rd(4'h0, d);
        chk_cnt++;
        if (d !== 16'h0001) $display("FAIL b2b_read0: got %h want 0001", d);
        else pass_cnt++;
        rd(4'hF, d);
        chk_cnt++;
        if (d !== 16'hFFFF) $display("FAIL b2b_readF: got %h want FFFF", d);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid_frame();
        int v0, f0, h0;
        logic [31:0] w;
        logic [15:0] d;
        w = mkframe(12'h001, 4'h6, 16'h4444);
        v0 = n_valid; f0 = n_ferr; h0 = n_herr;
        frame_start();
        for (int i = 31; i >= 15; i--) serial_bit(w[i]);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL rst_mid_busy: got %b want 1", busy);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        sclk = 1'b0;
        strobe = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        repeat (12) @(negedge clk);
        chk_cnt++;
        if (n_valid !== v0 || n_ferr !== f0 || n_herr !== h0 || busy !== 1'b0) begin
            $display("FAIL rst_mid_quiet: got v%0d f%0d h%0d busy%b want v%0d f%0d h%0d busy0",
                     n_valid, n_ferr, n_herr, busy, v0, f0, h0);
        end else pass_cnt++;
        shift_frame({32'h0, mkframe(12'h001, 4'h7, 16'h00A5)}, 32);
        repeat (8) @(negedge clk);
        model[7] = 16'h00A5;
        chk_cnt++;
        if (n_valid !== v0 + 1 || wr_q[wr_q.size() - 1] !== 20'h700A5) begin
            $display("FAIL rst_mid_next: got v%0d %h want v%0d 700A5",
                     n_valid, wr_q[wr_q.size() - 1], v0 + 1);
        end else pass_cnt++;
        rd(4'h7, d);
        chk_cnt++;
        if (d !== 16'h00A5) $display("FAIL rst_mid_read7: got %h want 00A5", d);
        else pass_cnt++;
        rd(4'hF, d);
        chk_cnt++;
        if (d !== model[15]) $display("FAIL rst_mid_readF: got %h want %h", d, model[15]);
        else pass_cnt++;
    endtask

    task automatic test_adc_reset();
        int v0;
        logic [15:0] d;
        shift_frame({32'h0, mkframe(12'h001, 4'h2, 16'h5A5A)}, 32);
        repeat (8) @(negedge clk);
        model[2] = 16'h5A5A;
        rd(4'h2, d);
        chk_cnt++;
        if (d !== 16'h5A5A) $display("FAIL adcrst_pre: got %h want 5A5A", d);
        else pass_cnt++;
        v0 = n_valid;
        @(negedge clk);
        adc_reset = 1'b1;
        @(negedge clk);
        adc_reset = 1'b0;
        clear_model();
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (n_valid !== v0) $display("FAIL adcrst_novalid: got %0d want %0d", n_valid, v0);
        else pass_cnt++;
        rd(4'h2, d);
        chk_cnt++;
        if (d !== 16'h0000) $display("FAIL adcrst_read2: got %h want 0000", d);
        else pass_cnt++;
    endtask

    task automatic test_adc_reset_in_check();
        int v0;
        logic [15:0] d;
        v0 = n_valid;
        shift_frame({32'h0, mkframe(12'h001, 4'h9, 16'hCAFE)}, 32);
        repeat (3) @(posedge clk);
        @(negedge clk);
        adc_reset = 1'b1;
        @(negedge clk);
        adc_reset = 1'b0;
        clear_model();
        repeat (6) @(negedge clk);
        chk_cnt++;
        if (n_valid !== v0 + 1 || wr_q[wr_q.size() - 1] !== 20'h9CAFE) begin
            $display("FAIL adcrst_check_pulse: got v%0d %h want v%0d 9CAFE",
                     n_valid, wr_q[wr_q.size() - 1], v0 + 1);
        end else pass_cnt++;
        rd(4'h9, d);
        chk_cnt++;
        if (d !== 16'h0000) $display("FAIL adcrst_check_read9: got %h want 0000", d);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int exp_v, exp_f, exp_h, n, r;
        logic [63:0] bits;
        logic [11:0] h;
        logic [15:0] d;
        exp_v = n_valid; exp_f = n_ferr; exp_h = n_herr;
        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, 9);
            n = (r < 7) ? 32 : (r == 7) ? 31 : (r == 8) ? 33 : 34;
            h = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h001;
            bits = {32'($urandom), h, 4'($urandom), 16'($urandom)};
            shift_frame(bits, n);
            if (n != 32) exp_f++;
            else if (bits[31:20] != 12'h001) exp_h++;
            else begin
                exp_v++;
                model[bits[19:16]] = bits[15:0];
            end
            repeat (8 + $urandom_range(0, 3)) @(negedge clk);
            chk_cnt++;
            if (n_valid !== exp_v || n_ferr !== exp_f || n_herr !== exp_h) begin
                $display("FAIL rand%0d_events: got v%0d f%0d h%0d want v%0d f%0d h%0d",
                         it, n_valid, n_ferr, n_herr, exp_v, exp_f, exp_h);
            end else pass_cnt++;
            if (n == 32 && bits[31:20] == 12'h001) begin
                chk_cnt++;
                if (wr_q[wr_q.size() - 1] !== bits[19:0]) begin
                    $display("FAIL rand%0d_write: got %h want %h", it, wr_q[wr_q.size() - 1], bits[19:0]);
                end else pass_cnt++;
            end
        end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d);
            chk_cnt++;
            if (d !== model[i]) $display("FAIL rand_reg%0d: got %h want %h", i, d, model[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_beef();
        test_hdr_err();
        test_frame_len();
        test_simultaneous();
        test_back_to_back();
        test_rst_mid_frame();
        test_adc_reset();
        test_adc_reset_in_check();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
